matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
- Sequencer that sits in front of the parameterised N×N 8-bit matrix multiplier (trigmult/A/B/Res interface).
- Accepts A then B as a row-major byte stream over valid/ready and assembles them into the packed operand buses.
- Fires the multiplier with a single-cycle trigmult pulse, waits the multiplier latency, then streams the N*N result bytes out over valid/ready.
- Serves as the glue between a byte-serial host link (UART/FIFO) and the multiplier.

Parameters:
- N, 2, matrix dimension; element (i,j) occupies packed bits [(i*N+j)*8 +: 8].
- MULT_LAT, 1, clock edges from the trigmult-high edge until Res_in is valid; range 1..15.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  operand byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  controller accepts in_data this cycle.
- out_data  output  8  result byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts out_data.
- A_out  output  N*N*8  packed matrix A to the multiplier.
- B_out  output  N*N*8  packed matrix B to the multiplier.
- trigmult  output  1  multiplier start strobe.
- Res_in  input  N*N*8  packed result from the multiplier.
- busy  output  1  high in every state except LOAD_A with idx==0.
- done  output  1  one-cycle pulse on the final result byte handshake.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, A_out=0, B_out=0, trigmult=0, done=0, busy=0, state=LOAD_A, idx=0, lat_cnt=0. From the first cycle after rst falls, in_ready=1.
- Handshake: a transfer occurs on a posedge where valid&&ready. in_valid during a state with in_ready=0 is ignored, with no buffering.
- idx is an element counter of width $clog2(N*N+1). Byte k of a stream maps to element k (row-major, k=i*N+j).

States:
- LOAD_A: in_ready=1. On a transfer, write A_out[idx*8 +: 8]=in_data. If idx==N*N-1, set idx=0 and go to LOAD_B; otherwise idx++.
- LOAD_B: same as LOAD_A but writes B_out. The last byte goes to TRIG.
- TRIG: trigmult=1 for exactly one cycle; in_ready=0. Load lat_cnt=MULT_LAT-1, then go to WAIT.
- WAIT: trigmult=0. If lat_cnt==0, go to SEND with idx=0; otherwise lat_cnt--. With MULT_LAT=1, WAIT lasts one cycle.
- SEND: out_valid=1, out_data=Res_in[idx*8 +: 8] (registered, valid in the same cycle out_valid rises).
  - On a transfer, idx++ and out_data advances to the next byte.
  - While out_ready=0, out_valid and out_data hold stable.
  - The transfer of byte N*N-1 pulses done, drops out_valid, clears idx, and returns to LOAD_A.

Rules:
- A_out/B_out hold their last values between jobs; the next job overwrites every byte.
- Res_in must stay stable through SEND. trigmult is never asserted outside TRIG, which guarantees this.
- Arithmetic is owned by the multiplier. Results are element sums truncated mod 256; the controller passes bytes through unaltered.
- Back-to-back jobs: the first A byte of the next job is accepted in the cycle after done at the earliest, because in_ready is 0 during SEND.
- Reset mid-operation (any state): all state and outputs return to reset values next edge. A partially loaded job is discarded, a pending trigmult is not issued, and an in-progress SEND stops with out_valid=0 and no done pulse.
- Exactly one trigmult pulse per completed load of 2*N*N bytes.

Test Plan:
- Basic (N=2, multiplier attached), out_ready=1: send A=1,2,3,4 and B=9,8,7,6 -> out bytes 23,20,55,48 in order; done pulses once on byte 4. trigmult is high exactly 1 cycle, 2*N*N cycles after the first accepted byte plus 0 idle.
- Overflow: A all 255, B all 1 -> every result 254. A all 16, B all 16 -> every result 0.
- Backpressure: out_ready toggles 0,0,1,0,1… during SEND -> out_data/out_valid are stable while stalled; all 4 bytes arrive in order, none duplicated or dropped.
- Input gaps: in_valid deasserted randomly during LOAD_A/LOAD_B; in_valid held high during TRIG/WAIT/SEND -> only 8 bytes consumed, extra bytes ignored; results match the basic test.
- Reset mid-load: rst for 1 cycle after 3 bytes of B -> outputs at reset values, no trigmult. The next full job (A=2,0,0,2, B=1,2,3,4) yields 2,4,6,8.
- MULT_LAT=3 with a delayed multiplier model: trigmult-to-out_valid is 4 cycles. Two back-to-back jobs produce correct independent results.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
//
// Purpose:
//   Byte-serial front end for an N x N 8-bit matrix multiplier. Collects
//   matrix A and then matrix B as row-major byte streams over valid/ready. It
//   packs both into the operand buses and fires the multiplier with a
//   one-cycle trigmult strobe. After the multiplier latency it streams the
//   N*N result bytes back out over valid/ready.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_data/in_valid/      operand byte stream (A bytes 0..N*N-1, then B)
//   in_ready
//   out_data/out_valid/    result byte stream (row-major)
//   out_ready
//   A_out, B_out           packed operands, element (i,j) at [(i*N+j)*8 +: 8]
//   trigmult               multiplier start strobe (one cycle per job)
//   Res_in                 packed multiplier result, same packing as A_out
//   busy                   low only when idle (loading A, nothing accepted)
//   done                   high during the handshake of the last result byte
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int N        = 2,
    parameter int MULT_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*N*8-1:0]   A_out,
    output logic [N*N*8-1:0]   B_out,
    output logic               trigmult,
    input  logic [N*N*8-1:0]   Res_in,
    output logic               busy,
    output logic               done
);

    localparam int             NN       = N * N;
    localparam int             IW       = $clog2(NN + 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NN - 1);
    localparam logic [3:0]     LAT_LOAD = 4'(MULT_LAT - 1);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_TRIG,
        S_WAIT,
        S_SEND
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_lat_cnt;
    logic [7:0]      r_out_data;
    logic            r_out_valid;

    logic            w_loading;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_idx_last;
    logic [IW-1:0]   w_res_sel;
    logic [7:0]      w_res_byte;

    assign w_loading  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_in_xfer  = w_loading && in_valid;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_idx_last = (r_idx == LAST_IDX);

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD_A: if (w_in_xfer && w_idx_last)  w_state_next = S_LOAD_B;
            S_LOAD_B: if (w_in_xfer && w_idx_last)  w_state_next = S_TRIG;
            S_TRIG:                                 w_state_next = S_WAIT;
            S_WAIT:   if (r_lat_cnt == 4'd0)        w_state_next = S_SEND;
            S_SEND:   if (w_out_xfer && w_idx_last) w_state_next = S_LOAD_A;
            default:                                w_state_next = S_LOAD_A;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: state-decoded outputs. Held low while rst is asserted so
    // that a reset mid-job never lets a strobe or handshake escape.
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        trigmult = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        if (!rst) begin
            in_ready = w_loading;
            trigmult = (r_state == S_TRIG);
            busy     = !((r_state == S_LOAD_A) && (r_idx == '0));
            done     = (r_state == S_SEND) && w_out_xfer && w_idx_last;
        end
    end

    // -------------------------------------------------------------------------
    // Result byte selection. Entering SEND presents byte 0; each accepted
    // byte preloads the next one so out_data is registered yet never lags.
    // -------------------------------------------------------------------------
    assign w_res_sel = (r_state == S_WAIT) ? '0 : (r_idx + IW'(1));

    always_comb begin
        w_res_byte = '0;
        for (int k = 0; k < NN; k++) begin
            if (w_res_sel == IW'(k)) begin
                w_res_byte = Res_in[k*8 +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Counters and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_lat_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD_A, S_LOAD_B: begin
                    if (w_in_xfer) begin
                        r_idx <= w_idx_last ? '0 : (r_idx + IW'(1));
                    end
                end
                S_TRIG: begin
                    r_lat_cnt <= LAT_LOAD;
                end
                S_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_res_byte;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                S_SEND: begin
                    if (w_out_xfer) begin
                        if (w_idx_last) begin
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_idx      <= r_idx + IW'(1);
                            r_out_data <= w_res_byte;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Operand storage: one byte register per element of A and of B. The
    // registers keep their contents between jobs.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NN; gi++) begin : g_elem
        logic [7:0] r_a_byte;
        logic [7:0] r_b_byte;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_a_byte <= '0;
                r_b_byte <= '0;
            end else if (w_in_xfer && (r_idx == IW'(gi))) begin
                if (r_state == S_LOAD_A) begin
                    r_a_byte <= in_data;
                end else begin
                    r_b_byte <= in_data;
                end
            end
        end

        assign A_out[gi*8 +: 8] = r_a_byte;
        assign B_out[gi*8 +: 8] = r_b_byte;
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_seq_ctrl
//
// Two controllers share one stimulus port: one uses MULT_LAT=1 and one uses
// MULT_LAT=3. Each has its own behavioural multiplier. 'sel' chooses which
// controller the stimulus drives and which one is observed.
// -----------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

    localparam int N  = 2;
    localparam int NN = N * N;
    localparam int W  = NN * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel       = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;

    int errors    = 0;
    int checks    = 0;
    int trig_cnt  = 0;

    // Per-instance signals
    logic         in_ready1, out_valid1, trig1, busy1, done1;
    logic [7:0]   out_data1;
    logic [W-1:0] a1, b1;
    logic [W-1:0] res1 = '0;
    logic         in_ready3, out_valid3, trig3, busy3, done3;
    logic [7:0]   out_data3;
    logic [W-1:0] a3, b3;
    logic [W-1:0] res3 = '0;

    // Observed (selected) view
    logic         in_ready, out_valid, trigmult, busy, done;
    logic [7:0]   out_data;
    logic [W-1:0] A_out, B_out;

    assign in_ready  = sel ? in_ready3  : in_ready1;
    assign out_valid = sel ? out_valid3 : out_valid1;
    assign trigmult  = sel ? trig3      : trig1;
    assign busy      = sel ? busy3      : busy1;
    assign done      = sel ? done3      : done1;
    assign out_data  = sel ? out_data3  : out_data1;
    assign A_out     = sel ? a3         : a1;
    assign B_out     = sel ? b3         : b1;

    matmul_seq_ctrl #(.N(N), .MULT_LAT(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid && !sel),
        .in_ready  (in_ready1),
        .out_data  (out_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .A_out     (a1),
        .B_out     (b1),
        .trigmult  (trig1),
        .Res_in    (res1),
        .busy      (busy1),
        .done      (done1)
    );

    matmul_seq_ctrl #(.N(N), .MULT_LAT(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid && sel),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .A_out     (a3),
        .B_out     (b3),
        .trigmult  (trig3),
        .Res_in    (res3),
        .busy      (busy3),
        .done      (done3)
    );

    // Behavioural multiplier: element sums truncated mod 256
    function automatic logic [W-1:0] mat_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [7:0]   s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 8'h00;
                for (int k = 0; k < N; k++) begin
                    s = 8'(s + a[(i*N+k)*8 +: 8] * b[(k*N+j)*8 +: 8]);
                end
                r[(i*N+j)*8 +: 8] = s;
            end
        end
        return r;
    endfunction

    // Latency-1 multiplier: result valid right after the strobe-sampling edge
    always @(posedge clk) begin
        if (trig1) res1 <= mat_mul(a1, b1);
    end

    // Latency-3 multiplier: garbage while computing, result two edges later
    logic [3:0]   cnt3 = 4'd0;
    logic [W-1:0] pend3 = '0;
    always @(posedge clk) begin
        if (trig3) begin
            pend3 <= mat_mul(a3, b3);
            res3  <= '1;
            cnt3  <= 4'd2;
        end else if (cnt3 != 4'd0) begin
            cnt3 <= cnt3 - 4'd1;
            if (cnt3 == 4'd1) res3 <= pend3;
        end
    end

    always @(negedge clk) begin
        if (trig1 || trig3) trig_cnt++;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one byte, wait (bounded) for acceptance. Called at a negedge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Byte k of av/bv is bits [(3-k)*8 +: 8]
    task automatic load_job(input logic [31:0] av, input logic [31:0] bv, input bit gaps);
        logic [31:0] v;
        int          kk;
        for (int k = 0; k < 2*NN; k++) begin
            v  = (k < NN) ? av : bv;
            kk = k % NN;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(v[(3-kk)*8 +: 8]);
        end
    endtask

    // Drain the result stream and check order, done, and stall stability.
    task automatic collect(input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input bit bp, input bit drop_valid);
        logic [7:0] exp_b [4];
        logic [7:0] prev_d;
        logic       exp_done;
        bit         stalled;
        int         k, c, sc;
        exp_b   = '{e0, e1, e2, e3};
        k = 0; c = 0; sc = 0;
        stalled = 1'b0;
        prev_d  = 8'h00;
        while (k < NN && c < 200) begin
            out_ready = bp ? ((sc >= 2) && (sc % 2 == 0)) : 1'b1;
            #1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_d) begin
                    errors++;
                    $display("FAIL stall_hold: out_valid=%0b out_data=%0d required 1 and %0d",
                             out_valid, out_data, prev_d);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== exp_b[k]) begin
                    errors++;
                    $display("FAIL out_byte%0d: got %0d expected %0d", k, out_data, exp_b[k]);
                end
                exp_done = (k == NN-1) ? 1'b1 : 1'b0;
                checks++;
                if (done !== exp_done) begin
                    errors++;
                    $display("FAIL done_byte%0d: got %0b expected %0b", k, done, exp_done);
                end
                if (k == NN-1 && drop_valid) in_valid = 1'b0;
                k++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                prev_d  = out_data;
                if (out_valid) begin
                    checks++;
                    if (done !== 1'b0) begin
                        errors++;
                        $display("FAIL done_stall: got %0b expected 0", done);
                    end
                end
            end
            if (out_valid) sc++;
            @(negedge clk);
            c++;
        end
        out_ready = 1'b0;
        checks++;
        if (k < NN) begin
            errors++;
            $display("FAIL collect_timeout: bytes=%0d required %0d", k, NN);
        end
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_job: out_valid=%0b busy=%0b in_ready=%0b required 0 0 1",
                     out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            trigmult !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%0b out_valid=%0b out_data=%0d trig=%0b done=%0b busy=%0b required all 0",
                     in_ready, out_valid, out_data, trigmult, done, busy);
        end
        checks++;
        if (A_out !== '0 || B_out !== '0) begin
            errors++;
            $display("FAIL reset_ops: A_out=%h B_out=%h required 0", A_out, B_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_exit: in_ready=%0b busy=%0b required 1 0", in_ready, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int t0;
        t0 = trig_cnt;
        send_byte(8'd1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_loading: got %0b expected 1", busy);
        end
        send_byte(8'd2); send_byte(8'd3); send_byte(8'd4);
        send_byte(8'd9); send_byte(8'd8); send_byte(8'd7); send_byte(8'd6);
        checks++;
        if (trigmult !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL trig_high: trigmult=%0b in_ready=%0b required 1 0", trigmult, in_ready);
        end
        checks++;
        if (A_out !== 32'h04030201 || B_out !== 32'h06070809) begin
            errors++;
            $display("FAIL packing: A_out=%h B_out=%h required 04030201 06070809", A_out, B_out);
        end
        @(negedge clk);
        checks++;
        if (trigmult !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_cycle: trigmult=%0b out_valid=%0b required 0 0", trigmult, out_valid);
        end
        collect(8'd23, 8'd20, 8'd55, 8'd48, 1'b0, 1'b0);
        checks++;
        if (trig_cnt - t0 !== 1) begin
            errors++;
            $display("FAIL trig_count_basic: got %0d expected 1", trig_cnt - t0);
        end
    endtask

    task automatic test_overflow();
        load_job(32'hFFFFFFFF, 32'h01010101, 1'b0);
        collect(8'd254, 8'd254, 8'd254, 8'd254, 1'b0, 1'b0);
        load_job(32'h10101010, 32'h10101010, 1'b0);
        collect(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        load_job(32'h01020304, 32'h09080706, 1'b0);
        collect(8'd23, 8'd20, 8'd55, 8'd48, 1'b1, 1'b0);
    endtask

    task automatic test_gaps();
        int t0;
        t0 = trig_cnt;
        load_job(32'h01020304, 32'h09080706, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        collect(8'd23, 8'd20, 8'd55, 8'd48, 1'b0, 1'b1);
        checks++;
        if (A_out !== 32'h04030201 || B_out !== 32'h06070809) begin
            errors++;
            $display("FAIL gaps_operands: A_out=%h B_out=%h required 04030201 06070809", A_out, B_out);
        end
        checks++;
        if (trig_cnt - t0 !== 1) begin
            errors++;
            $display("FAIL trig_count_gaps: got %0d expected 1", trig_cnt - t0);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        t0 = trig_cnt;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (A_out !== '0 || B_out !== '0 || in_ready !== 1'b0 || busy !== 1'b0 ||
            out_valid !== 1'b0 || trigmult !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: A=%h B=%h in_ready=%0b busy=%0b out_valid=%0b trig=%0b required zeros",
                     A_out, B_out, in_ready, busy, out_valid, trigmult);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (trig_cnt !== t0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_trig: trig pulses=%0d busy=%0b required 0 0", trig_cnt - t0, busy);
        end
        load_job(32'h02000002, 32'h01020304, 1'b0);
        collect(8'd2, 8'd4, 8'd6, 8'd8, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n;
        sel = 1'b1;
        #1;
        @(negedge clk);
        load_job(32'h01020304, 32'h09080706, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL lat3_delay: got %0d cycles expected 4", n);
        end
        collect(8'd23, 8'd20, 8'd55, 8'd48, 1'b0, 1'b0);
        load_job(32'h02000002, 32'h01020304, 1'b0);
        collect(8'd2, 8'd4, 8'd6, 8'd8, 1'b0, 1'b0);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
